// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/acknowledge bus between the MEM-stage controller and data memory.
// Handshake: req rises with we/addr/wdata stable and stays high until the cycle ack is seen; rdata/err are valid only with ack.
interface mem_stage_ctrl_if #(
  parameter int WORD_LEN = 16
);
  logic                req;
  logic                we;
  logic [WORD_LEN-1:0] addr;
  logic [WORD_LEN-1:0] wdata;
  logic                ack;
  logic [WORD_LEN-1:0] rdata;
  logic                err;

  modport master (output req, we, addr, wdata, input ack, rdata, err);
  modport slave  (input req, we, addr, wdata, output ack, rdata, err);
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: issues data-memory accesses from EX/MEM, stalls upstream while
// the access is outstanding, and holds the MEM/WB register presented to write-back.
module mem_stage_ctrl #(
  parameter int WORD_LEN  = 16,
  parameter int INSTR_LEN = 19,
  parameter int TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_ex_valid,
  input  logic                 i_ex_mem_read,
  input  logic                 i_ex_mem_write,
  input  logic                 i_ex_rf_write_en,
  input  logic                 i_ex_sel_wb_mem,
  input  logic [WORD_LEN-1:0]  i_ex_alu_out,
  input  logic [WORD_LEN-1:0]  i_ex_rf_out2,
  input  logic [INSTR_LEN-1:0] i_ex_instruction,
  mem_stage_ctrl_if.master     dmem,
  output logic                 o_stall,
  output logic                 o_wb_valid,
  output logic                 o_wb_rf_write_en,
  output logic [WORD_LEN-1:0]  o_wb_data,
  output logic [INSTR_LEN-1:0] o_wb_instruction,
  output logic                 o_mem_fault,
  output logic                 o_dbg_state
);

  localparam int CW = ($clog2(TIMEOUT) > 4) ? $clog2(TIMEOUT) : 4;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic                 r_req;
  logic                 r_we;
  logic [WORD_LEN-1:0]  r_addr;
  logic [WORD_LEN-1:0]  r_wdata;
  logic                 r_wb_valid;
  logic                 r_wb_rf_we;
  logic [WORD_LEN-1:0]  r_wb_data;
  logic [INSTR_LEN-1:0] r_wb_instr;
  logic                 r_fault;

  logic w_mem_op;
  logic w_timeout;

  // A simultaneous read+write request is issued as a write.
  assign w_mem_op  = i_ex_valid & (i_ex_mem_read | i_ex_mem_write);
  assign w_timeout = (r_cnt == CNT_LAST);

  always_comb begin
    o_stall = 1'b0;
    if (!rst) begin
      if (r_state == S_IDLE) o_stall = w_mem_op;
      else                   o_stall = ~(dmem.ack | w_timeout);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wb_valid <= 1'b0;
      r_wb_rf_we <= 1'b0;
      r_wb_data  <= '0;
      r_wb_instr <= '0;
      r_fault    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_mem_op) begin
            r_req      <= 1'b1;
            r_we       <= i_ex_mem_write;
            r_addr     <= i_ex_alu_out;
            r_wdata    <= i_ex_rf_out2;
            r_wb_valid <= 1'b0;
            r_cnt      <= '0;
            r_state    <= S_WAIT;
          end else begin
            r_wb_valid <= i_ex_valid;
            r_wb_rf_we <= i_ex_rf_write_en;
            r_wb_data  <= i_ex_alu_out;
            r_wb_instr <= i_ex_instruction;
            r_fault    <= 1'b0;
          end
        end
        S_WAIT: begin
          if (!w_timeout) r_cnt <= r_cnt + 1'b1;
          // Ack takes priority over a timeout landing in the same cycle.
          if (dmem.ack) begin
            r_req      <= 1'b0;
            r_state    <= S_IDLE;
            r_wb_valid <= 1'b1;
            r_wb_instr <= i_ex_instruction;
            r_wb_data  <= (~r_we & i_ex_sel_wb_mem) ? dmem.rdata : i_ex_alu_out;
            r_fault    <= dmem.err;
            r_wb_rf_we <= i_ex_rf_write_en & ~dmem.err;
          end else if (w_timeout) begin
            r_req      <= 1'b0;
            r_state    <= S_IDLE;
            r_wb_valid <= 1'b1;
            r_wb_instr <= i_ex_instruction;
            r_wb_data  <= '0;
            r_fault    <= 1'b1;
            r_wb_rf_we <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dmem.req         = r_req;
  assign dmem.we          = r_we;
  assign dmem.addr        = r_addr;
  assign dmem.wdata       = r_wdata;
  assign o_wb_valid       = r_wb_valid;
  assign o_wb_rf_write_en = r_wb_rf_we;
  assign o_wb_data        = r_wb_data;
  assign o_wb_instruction = r_wb_instr;
  assign o_mem_fault      = r_fault;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: transaction-level model checked every cycle,
// plus literal expectations for the main scenarios.
module tb_mem_stage_ctrl;
  localparam int W = 16;
  localparam int I = 19;
  localparam int TIMEOUT = 15;

  logic         clk;
  logic         rst;
  logic         ex_valid, ex_rd, ex_wr, ex_rfwe, ex_sel;
  logic [W-1:0] ex_alu, ex_rf2;
  logic [I-1:0] ex_instr;
  logic         stall, wb_valid, wb_rfwe, fault, dbg_state;
  logic [W-1:0] wb_data;
  logic [I-1:0] wb_instr;

  mem_stage_ctrl_if #(.WORD_LEN(W)) dmem_if ();

  mem_stage_ctrl #(.WORD_LEN(W), .INSTR_LEN(I), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .i_ex_valid(ex_valid), .i_ex_mem_read(ex_rd), .i_ex_mem_write(ex_wr),
    .i_ex_rf_write_en(ex_rfwe), .i_ex_sel_wb_mem(ex_sel),
    .i_ex_alu_out(ex_alu), .i_ex_rf_out2(ex_rf2), .i_ex_instruction(ex_instr),
    .dmem(dmem_if),
    .o_stall(stall), .o_wb_valid(wb_valid), .o_wb_rf_write_en(wb_rfwe),
    .o_wb_data(wb_data), .o_wb_instruction(wb_instr), .o_mem_fault(fault),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model: one outstanding access at a time, tracked as a transaction with an elapsed-wait count.
  logic         m_busy;
  int           m_waited;
  logic         m_we;
  logic [W-1:0] m_addr, m_wdata;
  logic         m_wb_valid, m_wb_rfwe, m_fault;
  logic [W-1:0] m_wb_data;
  logic [I-1:0] m_wb_instr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_waited = 0; m_we = 0; m_addr = 0; m_wdata = 0;
      m_wb_valid = 0; m_wb_rfwe = 0; m_fault = 0; m_wb_data = 0; m_wb_instr = 0;
    end else if (!m_busy) begin
      if (ex_valid && (ex_rd || ex_wr)) begin
        m_busy = 1; m_waited = 0; m_we = ex_wr; m_addr = ex_alu; m_wdata = ex_rf2;
        m_wb_valid = 0;
      end else begin
        m_wb_valid = ex_valid; m_wb_rfwe = ex_rfwe; m_wb_data = ex_alu;
        m_wb_instr = ex_instr; m_fault = 0;
      end
    end else if (dmem_if.ack) begin
      m_busy = 0; m_wb_valid = 1; m_wb_instr = ex_instr;
      m_wb_data = (!m_we && ex_sel) ? dmem_if.rdata : ex_alu;
      m_fault = dmem_if.err; m_wb_rfwe = ex_rfwe && !dmem_if.err;
    end else if (m_waited == TIMEOUT - 1) begin
      m_busy = 0; m_wb_valid = 1; m_wb_instr = ex_instr;
      m_wb_data = 0; m_fault = 1; m_wb_rfwe = 0;
    end else begin
      m_waited++;
    end
  end

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    logic exp_stall;
    if (rst) exp_stall = 0;
    else if (!m_busy) exp_stall = ex_valid & (ex_rd | ex_wr);
    else exp_stall = !(dmem_if.ack || m_waited == TIMEOUT - 1);
    check("stall", {31'b0, stall}, {31'b0, exp_stall});
    check("dmem_req", {31'b0, dmem_if.req}, {31'b0, m_busy});
    if (m_busy) begin
      check("dmem_we", {31'b0, dmem_if.we}, {31'b0, m_we});
      check("dmem_addr", {16'b0, dmem_if.addr}, {16'b0, m_addr});
      check("dmem_wdata", {16'b0, dmem_if.wdata}, {16'b0, m_wdata});
    end
    check("wb_valid", {31'b0, wb_valid}, {31'b0, m_wb_valid});
    if (m_wb_valid) begin
      check("wb_rf_write_en", {31'b0, wb_rfwe}, {31'b0, m_wb_rfwe});
      check("wb_data", {16'b0, wb_data}, {16'b0, m_wb_data});
      check("wb_instruction", {13'b0, wb_instr}, {13'b0, m_wb_instr});
      check("mem_fault", {31'b0, fault}, {31'b0, m_fault});
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_ex(input logic v, rd, wr, rfwe, sel, input logic [W-1:0] alu, rf2,
                        input logic [I-1:0] instr);
    ex_valid = v; ex_rd = rd; ex_wr = wr; ex_rfwe = rfwe; ex_sel = sel;
    ex_alu = alu; ex_rf2 = rf2; ex_instr = instr;
  endtask

  task automatic set_nop();
    set_ex(0, 0, 0, 0, 0, W'($urandom_range(0, 16'hFFFF)), 16'h0, 19'h0);
  endtask

  // Issues one access, holds ex_* while stalled, acks in WAIT cycle ack_at (never if out of range).
  task automatic do_mem(input logic rd, wr, rfwe, sel, input logic [W-1:0] alu, rf2,
                        input logic [I-1:0] instr, input int ack_at, input logic err,
                        input logic [W-1:0] rdata, output int req_cycles,
                        output logic first_we, output logic [W-1:0] first_addr,
                        output logic [W-1:0] first_wdata);
    req_cycles = 0;
    first_we = 0; first_addr = 0; first_wdata = 0;
    set_ex(1, rd, wr, rfwe, sel, alu, rf2, instr);
    step();
    for (int w = 0; w < TIMEOUT + 2; w++) begin
      if (w == 0) begin
        first_we = dmem_if.we; first_addr = dmem_if.addr; first_wdata = dmem_if.wdata;
      end
      if (w == ack_at) begin
        dmem_if.ack = 1; dmem_if.rdata = rdata; dmem_if.err = err;
      end
      if (dmem_if.req) req_cycles++;
      if (w == ack_at || w == TIMEOUT - 1) begin
        step();
        break;
      end
      step();
    end
    dmem_if.ack = 0; dmem_if.err = 0; dmem_if.rdata = W'($urandom_range(0, 16'hFFFF));
    set_nop();
  endtask

  int           rc;
  logic         fwe;
  logic [W-1:0] faddr, fwdata;

  initial begin
    rst = 1;
    dmem_if.ack = 0; dmem_if.err = 0; dmem_if.rdata = 0;
    set_nop();
    step(); step();
    check("reset wb_valid", {31'b0, wb_valid}, 32'h0);
    check("reset dmem_req", {31'b0, dmem_if.req}, 32'h0);
    check("reset wb_data", {16'b0, wb_data}, 32'h0);
    rst = 0;
    step();

    // ALU op passes in one cycle
    set_ex(1, 0, 0, 1, 0, 16'h1234, 16'h0, 19'h01234);
    step();
    check("alu wb_valid", {31'b0, wb_valid}, 32'h1);
    check("alu wb_data", {16'b0, wb_data}, 32'h1234);
    check("alu wb_rfwe", {31'b0, wb_rfwe}, 32'h1);
    set_nop();
    step();

    // load, acked in third WAIT cycle
    do_mem(1, 0, 1, 1, 16'h0040, 16'h0, 19'h10040, 2, 0, 16'hBEEF, rc, fwe, faddr, fwdata);
    check("load req cycles", rc, 32'd3);
    check("load wb_data", {16'b0, wb_data}, 32'hBEEF);
    check("load wb_rfwe", {31'b0, wb_rfwe}, 32'h1);
    check("load addr", {16'b0, faddr}, 32'h0040);
    step();

    // store
    do_mem(0, 1, 0, 1, 16'h0010, 16'h00AA, 19'h20010, 1, 0, 16'h7777, rc, fwe, faddr, fwdata);
    check("store we", {31'b0, fwe}, 32'h1);
    check("store addr", {16'b0, faddr}, 32'h0010);
    check("store wdata", {16'b0, fwdata}, 32'h00AA);
    check("store wb_rfwe", {31'b0, wb_rfwe}, 32'h0);
    check("store fault", {31'b0, fault}, 32'h0);
    check("store wb_data", {16'b0, wb_data}, 32'h0010);
    step();

    // timeout, then back-to-back load completing normally
    do_mem(1, 0, 1, 1, 16'h0080, 16'h0, 19'h30080, 99, 0, 16'h0, rc, fwe, faddr, fwdata);
    check("timeout req cycles", rc, TIMEOUT);
    check("timeout fault", {31'b0, fault}, 32'h1);
    check("timeout wb_rfwe", {31'b0, wb_rfwe}, 32'h0);
    check("timeout wb_data", {16'b0, wb_data}, 32'h0);
    check("timeout wb_valid", {31'b0, wb_valid}, 32'h1);
    do_mem(1, 0, 1, 1, 16'h0082, 16'h0, 19'h30082, 1, 0, 16'h1357, rc, fwe, faddr, fwdata);
    check("post-timeout fault", {31'b0, fault}, 32'h0);
    check("post-timeout wb_data", {16'b0, wb_data}, 32'h1357);
    check("post-timeout wb_rfwe", {31'b0, wb_rfwe}, 32'h1);

    // load with error
    do_mem(1, 0, 1, 1, 16'h0090, 16'h0, 19'h40090, 0, 1, 16'hDEAD, rc, fwe, faddr, fwdata);
    check("err fault", {31'b0, fault}, 32'h1);
    check("err wb_rfwe", {31'b0, wb_rfwe}, 32'h0);

    // read and write together behaves as a store
    do_mem(1, 1, 0, 1, 16'h00A0, 16'h5555, 19'h500A0, 3, 0, 16'h9999, rc, fwe, faddr, fwdata);
    check("rdwr we", {31'b0, fwe}, 32'h1);
    check("rdwr wb_data", {16'b0, wb_data}, 32'h00A0);

    // stray ack while idle has no effect
    dmem_if.ack = 1; dmem_if.err = 1;
    set_ex(1, 0, 0, 1, 0, 16'h4321, 16'h0, 19'h04321);
    step();
    dmem_if.ack = 0; dmem_if.err = 0;
    check("stray ack fault", {31'b0, fault}, 32'h0);
    check("stray ack wb_data", {16'b0, wb_data}, 32'h4321);
    set_nop();
    step();

    // reset two cycles into WAIT
    set_ex(1, 1, 0, 1, 1, 16'h00C0, 16'h0, 19'h600C0);
    step(); step(); step();
    rst = 1;
    #1;
    check("rst dmem_req", {31'b0, dmem_if.req}, 32'h0);
    check("rst stall", {31'b0, stall}, 32'h0);
    check("rst wb_valid", {31'b0, wb_valid}, 32'h0);
    check("rst wb_rfwe", {31'b0, wb_rfwe}, 32'h0);
    check("rst wb_data", {16'b0, wb_data}, 32'h0);
    set_nop();
    step(); step();
    rst = 0;
    step();
    set_ex(1, 0, 0, 1, 0, 16'h5A5A, 16'h0, 19'h75A5A);
    step();
    check("post-rst wb_valid", {31'b0, wb_valid}, 32'h1);
    check("post-rst wb_data", {16'b0, wb_data}, 32'h5A5A);
    set_nop();
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
